pixel_frame_streamer: RTL



---
 rtl/pixel_frame_streamer_pkg.sv | 28 ++
 rtl/pixel_frame_streamer_if.sv | 43 ++++
 rtl/pixel_frame_streamer_ram.sv | 32 +++
 rtl/pixel_frame_streamer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pixel_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package : cnn_stream_pkg
// Brief   : Shared FSM states, kernel codes and defaults for the pixel streamer.
// Rev     : 1.0
// ============================================================================
package cnn_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam logic [1:0] K3        = 2'b00;
  localparam logic [1:0] K5        = 2'b01;
  localparam logic [1:0] K7        = 2'b10;
  localparam logic [1:0] K_INVALID = 2'b11;

  localparam int DEFAULT_DEPTH    = 64;
  localparam int DEFAULT_PIPE_LAT = 4;

  function automatic logic kernel_valid(input logic [1:0] code);
    return (code != K_INVALID);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface : pixel_frame_streamer_if
// Brief     : Host load/control, accelerator pixel path and result signals.
// Rev       : 1.0
// ============================================================================
interface pixel_frame_streamer_if #(
  parameter int AW = 6,
  parameter int CW = 7
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [1:0]    kernel_size_cfg;
  logic [7:0]    pixel_out;
  logic          pixel_valid;
  logic [1:0]    kernel_size;
  logic          detected;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [CW-1:0] hit_count;
  logic [AW-1:0] first_hit_idx;
  logic          hit;

  // Host and accelerator side
  modport master (
    output wr_en, wr_addr, wr_data, start, kernel_size_cfg, detected,
    input  pixel_out, pixel_valid, kernel_size, busy, done, cfg_err,
           hit_count, first_hit_idx, hit
  );

  // Streamer side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, kernel_size_cfg, detected,
    output pixel_out, pixel_valid, kernel_size, busy, done, cfg_err,
           hit_count, first_hit_idx, hit
  );

endinterface
`default_nettype wire

// File: rtl/pixel_frame_streamer_ram.sv
`default_nettype none
// ============================================================================
// Module : pixel_frame_ram
// Brief  : DEPTHx8 frame buffer, one write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module pixel_frame_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          wr_en_i,
  input  wire logic [AW-1:0] wr_addr_i,
  input  wire logic [7:0]    wr_data_i,
  input  wire logic          rd_en_i,
  input  wire logic [AW-1:0] rd_addr_i,
  output logic      [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module : pixel_frame_streamer
// Brief  : Streams a buffered frame into the accelerator and scores detections.
//          STREAMER_FIRST_HIT_EN builds the hit / first_hit_idx tracking.
// Rev    : 1.0
// ============================================================================
module pixel_frame_streamer
  import cnn_stream_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
  parameter int AW       = $clog2(DEPTH),
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input wire logic         clk,
  input wire logic         reset,
  pixel_frame_streamer_if.slave bus
);

  localparam int               CYW      = $clog2(DEPTH + PIPE_LAT + 2);
  localparam logic [CYW-1:0]   WIN_LO   = CYW'(PIPE_LAT);
  localparam logic [CYW-1:0]   WIN_HI   = CYW'(DEPTH - 1 + PIPE_LAT);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CYW-1:0] cyc_q, cyc_d;
  logic [1:0]    kernel_q, kernel_d;
  logic          pv_q, pv_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic [CW-1:0] hit_count_q, hit_count_d;

  logic          w_busy;
  logic          w_accept;
  logic          w_score;
  logic          w_rd_en;
  logic [7:0]    w_rd_data;

  assign w_busy   = (state_q != ST_IDLE);
  assign w_accept = (state_q == ST_IDLE) && bus.start && kernel_valid(bus.kernel_size_cfg);
  assign w_score  = w_busy && bus.detected && (cyc_q >= WIN_LO) && (cyc_q <= WIN_HI);
  assign w_rd_en  = (state_q == ST_STREAM);

  pixel_frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (bus.wr_en && !w_busy),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (w_rd_en),
    .rd_addr_i (idx_q),
    .rd_data_o (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cyc_q       <= '0;
      kernel_q    <= K3;
      pv_q        <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      kernel_q    <= kernel_d;
      pv_q        <= pv_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cyc_d       = cyc_q;
    kernel_d    = kernel_q;
    pv_d        = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    hit_count_d = hit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          kernel_d    = bus.kernel_size_cfg;
          idx_d       = '0;
          cyc_d       = '0;
          hit_count_d = '0;
          state_d     = ST_STREAM;
        end else if (bus.start) begin
          cfg_err_d = 1'b1;
        end
      end
      ST_STREAM: begin
        pv_d = 1'b0 | 1'b1;
        // cyc stays 0 through the first pixel_valid cycle
        if (pv_q) cyc_d = cyc_q + CYW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        cyc_d = cyc_q + CYW'(1);
        if (cyc_q == WIN_HI) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_score) hit_count_d = hit_count_q + CW'(1);
  end

`ifdef STREAMER_FIRST_HIT_EN
  logic          hit_q, hit_d;
  logic [AW-1:0] first_q, first_d;

  always_comb begin
    hit_d   = hit_q;
    first_d = first_q;
    if (w_accept) begin
      hit_d   = 1'b0;
      first_d = '0;
    end else if (w_score && !hit_q) begin
      hit_d   = 1'b1;
      first_d = AW'(cyc_q - WIN_LO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q   <= 1'b0;
      first_q <= '0;
    end else begin
      hit_q   <= hit_d;
      first_q <= first_d;
    end
  end

  assign bus.hit           = hit_q;
  assign bus.first_hit_idx = first_q;
`else
  assign bus.hit           = 1'b0;
  assign bus.first_hit_idx = '0;
`endif

  assign bus.pixel_out   = pv_q ? w_rd_data : 8'h00;
  assign bus.pixel_valid = pv_q;
  assign bus.kernel_size = kernel_q;
  assign bus.busy        = w_busy;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.hit_count   = hit_count_q;

endmodule
`default_nettype wire
